// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / MDU / control-flush hazard controller; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_jump,
    input  logic        ID_mdu_start,
    input  logic        ID_mdu_use,
    input  logic        EX_Mem_rd,
    input  logic [4:0]  EX_wr_addr,
    input  logic        EX_branch_taken,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic [1:0]  stall_cause,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu;
    logic             w_ms;

    assign w_lu = EX_Mem_rd && (EX_wr_addr != 5'd0) &&
                  ((ID_uses_rs && (ID_rs == EX_wr_addr)) ||
                   (ID_uses_rt && (ID_rt == EX_wr_addr)));
    assign w_ms = (r_state == MDU_BUSY) && (ID_mdu_use || ID_mdu_start);
    assign mdu_busy = (r_state == MDU_BUSY);

    // Reset forces the RUN defaults regardless of what the pipeline presents.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        stall_cause = 2'b00;
        if (reset) begin
            if (EX_branch_taken) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                stall_cause = 2'b11;
            end else if (w_lu) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
                stall_cause = 2'b01;
            end else if (w_ms) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
                stall_cause = 2'b10;
            end else if (ID_jump) begin
                IF_ID_flush = 1'b1;
                stall_cause = 2'b11;
            end
        end
    end

    // Busy window runs to completion; branches and stalls never cancel it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (ID_mdu_start && !EX_branch_taken && !w_lu) begin
                        r_state <= MDU_BUSY;
                        r_cnt   <= CNT_W'(MDU_LAT - 1);
                    end
                end
                MDU_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (((stall_cause == 2'b01) || (stall_cause == 2'b10)) &&
                (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((stall_cause == 2'b11) && (r_flush_cycles != 32'hFFFF_FFFF)) begin
                r_flush_cycles <= r_flush_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed plus randomized check of hazard_ctrl against a timestamp-based reference model
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_wr_addr;
    logic        ID_uses_rs, ID_uses_rt, ID_jump, ID_mdu_start, ID_mdu_use;
    logic        EX_Mem_rd, EX_branch_taken;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, mdu_busy;
    logic [1:0]  stall_cause;
    logic [31:0] stall_cycles, flush_cycles;

    int n_cmp;
    int n_bad;

    // Reference state: cycle index, cycle at which the last MDU op issued, perf totals.
    int      cyc;
    int      issue_cyc;
    bit      issue_valid;
    longint  m_stall;
    longint  m_flush;

    hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_jump(ID_jump), .ID_mdu_start(ID_mdu_start), .ID_mdu_use(ID_mdu_use),
        .EX_Mem_rd(EX_Mem_rd), .EX_wr_addr(EX_wr_addr), .EX_branch_taken(EX_branch_taken),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .stall_cause(stall_cause), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_busy();
        return issue_valid && (cyc - issue_cyc >= 1) && (cyc - issue_cyc <= LAT - 1);
    endfunction

    function automatic bit model_lu();
        return EX_Mem_rd && (EX_wr_addr != 0) &&
               ((ID_uses_rs && ID_rs == EX_wr_addr) || (ID_uses_rt && ID_rt == EX_wr_addr));
    endfunction

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, cause}
    function automatic logic [5:0] model_out();
        bit ms;
        ms = model_busy() && (ID_mdu_use || ID_mdu_start);
        if (EX_branch_taken) return {4'b1111, 2'b11};
        if (model_lu())      return {4'b0001, 2'b01};
        if (ms)              return {4'b0001, 2'b10};
        if (ID_jump)         return {4'b1110, 2'b11};
        return {4'b1100, 2'b00};
    endfunction

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; EX_wr_addr = 0;
        ID_uses_rs = 0; ID_uses_rt = 0; ID_jump = 0;
        ID_mdu_start = 0; ID_mdu_use = 0; EX_Mem_rd = 0; EX_branch_taken = 0;
    endtask

    task automatic model_reset();
        issue_valid = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Inputs already applied after a falling edge; check, clock, advance model.
    task automatic step(input string tag);
        logic [5:0] exp;
        #1;
        exp = model_out();
        check({tag, ".outs"}, {26'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_cause},
              {26'd0, exp});
        check({tag, ".busy"}, {31'd0, mdu_busy}, {31'd0, model_busy()});
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cycles, 32'(m_stall));
        check({tag, ".flush_cnt"}, flush_cycles, 32'(m_flush));
`else
        check({tag, ".stall_cnt"}, stall_cycles, 32'd0);
        check({tag, ".flush_cnt"}, flush_cycles, 32'd0);
`endif
        @(posedge clk);
        if (!model_busy() && ID_mdu_start && !EX_branch_taken && !model_lu()) begin
            issue_valid = 1;
            issue_cyc   = cyc;
        end
        if (exp[1:0] == 2'b01 || exp[1:0] == 2'b10) m_stall = (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
        if (exp[1:0] == 2'b11) m_flush = (m_flush < 64'hFFFF_FFFF) ? m_flush + 1 : m_flush;
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset while the current inputs are applied; outputs must fall back to defaults.
    task automatic reset_pulse(input string tag);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".outs"}, {26'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_cause},
              32'h30);
        check({tag, ".busy"}, {31'd0, mdu_busy}, 32'd0);
        check({tag, ".stall_cnt"}, stall_cycles, 32'd0);
        check({tag, ".flush_cnt"}, flush_cycles, 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; issue_cyc = 0;
        model_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.outs", {26'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_cause}, 32'h30);
        check("reset.busy", {31'd0, mdu_busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Load-use on rs, then same with $zero destination.
        EX_Mem_rd = 1; EX_wr_addr = 8; ID_rs = 8; ID_uses_rs = 1;
        step("lu");
        EX_wr_addr = 0; ID_rs = 0;
        step("lu_zero");
        check("lu_zero.pcw", {31'd0, PC_write}, 32'd1);

        // Branch wins over load-use.
        EX_wr_addr = 8; ID_rs = 8; EX_branch_taken = 1;
        step("br_over_lu");
        idle_inputs();

        // Jump with load-use stalls; flush happens once the hazard clears.
        ID_jump = 1; EX_Mem_rd = 1; EX_wr_addr = 5; ID_rt = 5; ID_uses_rt = 1;
        step("jump_lu");
        check("jump_lu.iff", {31'd0, IF_ID_flush}, 32'd0);
        EX_Mem_rd = 0;
        step("jump_after");
        idle_inputs();

        // MDU window: mult at cycle 0, mfhi stalled cycles 1-3, proceeds cycle 4.
        model_reset();
        reset_pulse("pre_mdu");
        ID_mdu_start = 1;
        step("mdu_issue");
        ID_mdu_start = 0; ID_mdu_use = 1;
        for (int i = 1; i <= 3; i++) begin
            check("mdu_win.cause", {30'd0, stall_cause}, 32'd2);
            step("mdu_win");
        end
        check("mdu_done.busy", {31'd0, mdu_busy}, 32'd0);
        check("mdu_done.pcw", {31'd0, PC_write}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("mdu_done.stall_cnt", stall_cycles, 32'd3);
`endif
        step("mdu_done");
        idle_inputs();

        // Back-to-back mult: second start held cycles 1-3, re-issues at cycle 4.
        ID_mdu_start = 1;
        for (int i = 0; i <= 4; i++) step("b2b");
        check("b2b.reissue_busy", {31'd0, mdu_busy}, 32'd1);
        ID_mdu_start = 0;
        step("b2b_tail");

        // Reset landing mid-busy, with a hazard presented.
        ID_mdu_use = 1; EX_Mem_rd = 1; EX_wr_addr = 3; ID_rs = 3; ID_uses_rs = 1;
        reset_pulse("rst_mid_busy");
        idle_inputs();
        step("post_rst");

        // Randomized traffic with a small register pool to make hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            ID_rs           = 5'($urandom_range(0, 3));
            ID_rt           = 5'($urandom_range(0, 3));
            EX_wr_addr      = 5'($urandom_range(0, 3));
            ID_uses_rs      = 1'($urandom_range(0, 1));
            ID_uses_rt      = 1'($urandom_range(0, 1));
            EX_Mem_rd       = ($urandom_range(0, 99) < 30);
            EX_branch_taken = ($urandom_range(0, 99) < 10);
            ID_jump         = ($urandom_range(0, 99) < 10);
            ID_mdu_start    = ($urandom_range(0, 99) < 15);
            ID_mdu_use      = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 199) == 0) reset_pulse("rand_rst");
            else step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
